// File: rtl/cpu_step_ctrl.sv
// Run/step controller: issues one-cycle cpu_step clock enables from CLK.
// Ports: CLK, Reset (sync, active-low), key_pulse, mode, run_count, bp_en,
//   bp_addr, pc in; cpu_step, running, halted_bp, step_count out.
module cpu_step_ctrl #(
    parameter int RATE_DIV = 25_000_000,
    parameter int PC_W     = 32
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            key_pulse,
    input  logic [1:0]      mode,
    input  logic [7:0]      run_count,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            cpu_step,
    output logic            running,
    output logic            halted_bp,
    output logic [15:0]     step_count
);

    localparam int TW = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(RATE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BREAK = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [1:0]      run_mode, run_mode_d;
    logic [7:0]      remaining, remaining_d;
    logic [TW-1:0]   tick, tick_d;
    logic            bp_en_q, bp_en_d;
    logic [PC_W-1:0] bp_addr_q, bp_addr_d;
    logic            strobe;
    logic            cpu_step_d, running_d, halted_d;
    logic [15:0]     step_count_d;

    // State and all registered outputs
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state      <= IDLE;
            run_mode   <= '0;
            remaining  <= '0;
            tick       <= '0;
            bp_en_q    <= 1'b0;
            bp_addr_q  <= '0;
            cpu_step   <= 1'b0;
            running    <= 1'b0;
            halted_bp  <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_d;
            run_mode   <= run_mode_d;
            remaining  <= remaining_d;
            tick       <= tick_d;
            bp_en_q    <= bp_en_d;
            bp_addr_q  <= bp_addr_d;
            cpu_step   <= cpu_step_d;
            running    <= running_d;
            halted_bp  <= halted_d;
            step_count <= step_count_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state;
        run_mode_d  = run_mode;
        remaining_d = remaining;
        tick_d      = tick;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        strobe      = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_pulse) begin
                    unique case (mode)
                        2'b00: strobe = 1'b1;
                        2'b01: begin
                            if (run_count != 8'd0) begin
                                remaining_d = run_count;
                                tick_d      = '0;
                                run_mode_d  = mode;
                                state_d     = RUN;
                            end
                        end
                        default: begin
                            tick_d     = '0;
                            run_mode_d = mode;
                            bp_en_d    = bp_en;
                            bp_addr_d  = bp_addr;
                            state_d    = RUN;
                        end
                    endcase
                end
            end
            RUN: begin
                // Abort wins over a tick landing on the same edge
                if (key_pulse) begin
                    tick_d  = '0;
                    state_d = IDLE;
                end else if (tick == TICK_MAX) begin
                    tick_d = '0;
                    if (run_mode == 2'b10 && bp_en_q && pc == bp_addr_q) begin
                        state_d = BREAK;
                    end else begin
                        strobe = 1'b1;
                        if (run_mode == 2'b01) begin
                            remaining_d = remaining - 8'd1;
                            if (remaining == 8'd1)
                                state_d = IDLE;
                        end
                    end
                end else begin
                    tick_d = tick + TW'(1);
                end
            end
            BREAK: begin
                // One strobe steps past the breakpoint
                if (key_pulse) begin
                    strobe  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        cpu_step_d   = strobe;
        running_d    = (state_d == RUN);
        halted_d     = (state_d == BREAK);
        step_count_d = step_count + {15'd0, strobe};
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with RATE_DIV=4.
// Covers step, run-N, N=0, breakpoint, abort, wrap and reset mid-run.
module tb_cpu_step_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        key_pulse;
    logic [1:0]  mode;
    logic [7:0]  run_count;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_step;
    logic        running;
    logic        halted_bp;
    logic [15:0] step_count;
    logic        pc_clr;

    int n_chk = 0;
    int n_pass = 0;

    cpu_step_ctrl #(.RATE_DIV(4), .PC_W(32)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .key_pulse(key_pulse),
        .mode(mode),
        .run_count(run_count),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc(pc),
        .cpu_step(cpu_step),
        .running(running),
        .halted_bp(halted_bp),
        .step_count(step_count)
    );

    always #5 CLK = ~CLK;

    // CPU model: pc advances by 4 on the edge after each strobe
    always @(posedge CLK) begin
        if (pc_clr)
            pc <= 32'd0;
        else if (cpu_step)
            pc <= pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press();
        key_pulse = 1'b1;
        step();
        key_pulse = 1'b0;
    endtask

    initial begin
        Reset     = 1'b0;
        key_pulse = 1'b0;
        mode      = 2'b00;
        run_count = 8'd0;
        bp_en     = 1'b0;
        bp_addr   = 32'd0;
        pc_clr    = 1'b1;
        repeat (3) step();
        Reset  = 1'b1;
        pc_clr = 1'b0;
        chk("rst_step", 16'(cpu_step), 16'd0);
        chk("rst_cnt", step_count, 16'd0);
        chk("rst_run", 16'(running), 16'd0);
        chk("rst_halt", 16'(halted_bp), 16'd0);

        // Single step
        repeat (5) step();
        mode = 2'b00;
        press();
        chk("st_step", 16'(cpu_step), 16'd1);
        chk("st_cnt", step_count, 16'd1);
        chk("st_run", 16'(running), 16'd0);
        step();
        chk("st_low", 16'(cpu_step), 16'd0);

        // Run-N with N=3
        mode      = 2'b01;
        run_count = 8'd3;
        press();
        chk("rn_run0", 16'(running), 16'd1);
        chk("rn_stp0", 16'(cpu_step), 16'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("rn_stp%0d", k), 16'(cpu_step),
                16'((k % 4 == 0) && (k <= 12)));
            chk($sformatf("rn_run%0d", k), 16'(running), 16'(k < 12));
        end
        chk("rn_cnt", step_count, 16'd4);

        // Run-N with N=0
        run_count = 8'd0;
        press();
        chk("n0_run", 16'(running), 16'd0);
        chk("n0_stp", 16'(cpu_step), 16'd0);
        repeat (6) step();
        chk("n0_cnt", step_count, 16'd4);

        // Breakpoint at 0x0C
        pc_clr = 1'b1;
        step();
        pc_clr  = 1'b0;
        mode    = 2'b10;
        bp_en   = 1'b1;
        bp_addr = 32'h0C;
        press();
        chk("bp_run0", 16'(running), 16'd1);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("bp_stp%0d", k), 16'(cpu_step),
                16'((k % 4 == 0) && (k < 16)));
            chk($sformatf("bp_halt%0d", k), 16'(halted_bp), 16'(k >= 16));
            chk($sformatf("bp_run%0d", k), 16'(running), 16'(k < 16));
        end
        chk("bp_cnt", step_count, 16'd7);
        repeat (6) step();
        chk("bp_hold", 16'(halted_bp), 16'd1);
        chk("bp_hstp", 16'(cpu_step), 16'd0);
        press();
        chk("bp_kstp", 16'(cpu_step), 16'd1);
        chk("bp_khalt", 16'(halted_bp), 16'd0);
        chk("bp_krun", 16'(running), 16'd0);
        chk("bp_kcnt", step_count, 16'd8);
        repeat (8) step();
        chk("bp_idle", 16'(cpu_step), 16'd0);
        chk("bp_icnt", step_count, 16'd8);

        // Abort coinciding with tick==3
        bp_en = 1'b0;
        mode  = 2'b11;
        press();
        repeat (3) step();
        press();
        chk("ab_stp", 16'(cpu_step), 16'd0);
        chk("ab_run", 16'(running), 16'd0);
        chk("ab_cnt", step_count, 16'd8);
        repeat (8) step();
        chk("ab_late", 16'(cpu_step), 16'd0);
        chk("ab_lcnt", step_count, 16'd8);

        // Fill counter to 0xFFFF, then wrap
        mode      = 2'b00;
        key_pulse = 1'b1;
        for (int i = 0; i < 65527; i++)
            step();
        key_pulse = 1'b0;
        step();
        chk("wr_full", step_count, 16'hFFFF);
        press();
        chk("wr_zero", step_count, 16'h0000);
        chk("wr_stp", 16'(cpu_step), 16'd1);

        // Reset mid free-run
        step();
        mode = 2'b11;
        press();
        repeat (2) step();
        chk("rr_pre", 16'(running), 16'd1);
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        chk("rr_run", 16'(running), 16'd0);
        chk("rr_stp", 16'(cpu_step), 16'd0);
        chk("rr_halt", 16'(halted_bp), 16'd0);
        chk("rr_cnt", step_count, 16'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("rr_nostp%0d", k), 16'(cpu_step), 16'd0);
        end
        chk("rr_cnt2", step_count, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Run/step controller that sequences the multi-cycle CPU from the board clock rather than clocking it directly from the debounced button. It sits between the key debouncer and the CPU. It issues single-cycle `cpu_step` clock-enable strobes in four modes:

- single-step
- run-N
- run-to-breakpoint
- free-run

It also exposes a step counter and status bits for the 7-segment display mux.

## Interface
Parameters:
- `RATE_DIV`, default 25_000_000: `CLK` cycles between automatic steps in run modes; minimum 2.
- `PC_W`, default 32: width of `pc` and `bp_addr`.

Ports:
- `CLK`, input, 1: board clock; the only clock.
- `Reset`, input, 1: one clock; reset is synchronous and active-low.
- `key_pulse`, input, 1: one-`CLK`-cycle pulse from the debouncer.
- `mode`, input, 2: selects the operating mode.
  - 00: step
  - 01: run-N
  - 10: run-to-breakpoint
  - 11: free-run
- `run_count`, input, 8: N for run-N; sampled at run start.
- `bp_en`, input, 1: breakpoint enable; sampled at run start.
- `bp_addr`, input, `PC_W`: breakpoint PC; sampled at run start.
- `pc`, input, `PC_W`: current CPU PC, valid while no step is pending.
- `cpu_step`, output, 1: CPU clock enable, high exactly one cycle per step.
- `running`, output, 1: high in RUN state.
- `halted_bp`, output, 1: high in BREAK state.
- `step_count`, output, 16: strobes issued since reset; wraps 0xFFFF→0.

## Operation
- Three states: IDLE, RUN, BREAK. All outputs are registered.
- Internal registers:
  - `run_mode` (2 bits)
  - `remaining` (8 bits)
  - tick counter, `ceil(log2(RATE_DIV))` bits
  - latched `bp_en` and `bp_addr`
- **IDLE**, on `key_pulse`:
  - mode 00: strobe `cpu_step`; stay in IDLE.
  - mode 01: if `run_count`==0, no action. Otherwise load `remaining`=`run_count`, clear tick, latch `run_mode`, go to RUN.
  - mode 10/11: clear tick, latch `run_mode`, `bp_en` and `bp_addr`, go to RUN.
- **RUN**:
  - The tick counter increments every cycle.
  - When tick==`RATE_DIV`-1, tick returns to 0 and a step decision is made, using `run_mode` only (the `mode` input is ignored during RUN):
    - `run_mode`=10, latched `bp_en`=1 and `pc`==latched `bp_addr`: no strobe, go to BREAK.
    - Otherwise: strobe `cpu_step`, and `step_count`+1.
    - `run_mode`=01: decrement `remaining`. If `remaining` was 1, go to IDLE in the same edge.
  - `key_pulse` in RUN aborts to IDLE with no strobe. This takes priority over a coincident tick.
- **BREAK**:
  - `halted_bp`=1.
  - `key_pulse` issues exactly one strobe (steps past the breakpoint) and goes to IDLE.
  - No other exit except reset.
- Every strobe increments `step_count` modulo 2^16.

## Timing
- Reset: when `Reset`=0 at a rising `CLK` edge, the block goes to IDLE and all outputs and internal registers clear to 0 after that edge. This applies in any state, including mid-RUN; a pending tick is discarded.
- Step mode latency: `key_pulse` sampled at edge E gives `cpu_step` high from E to E+1, then low.
- `step_count` updates on the same edge that raises `cpu_step`.
- Run entry at edge E gives strobes after edges E+`RATE_DIV`, E+2·`RATE_DIV`, and so on.
  - `running` rises after E.
  - In run-N, `running` falls on the edge that raises the Nth strobe.
- Breakpoint:
  - `pc` is compared at the tick edge.
  - The CPU updates `pc` within one cycle of a strobe; `RATE_DIV`≥2 guarantees `pc` is settled.
  - On a hit, `halted_bp` rises at the tick edge; `running` falls at the same edge.
- `cpu_step` is never high on two consecutive cycles.

## Test plan
- **Step mode:** `RATE_DIV`=4, mode=00, `key_pulse` at edge 10 → `cpu_step` high only in the cycle after edge 10; `step_count`=1; `running`=0.
- **Run-N:** mode=01, `run_count`=3, key at edge E → strobes after edges E+4, E+8, E+12; `running` 1→0 at E+12; `step_count`=3; no strobe at E+16.
- **Run-N with N=0:** mode=01, `run_count`=0, key → no strobe, `running` stays 0, `step_count` unchanged.
- **Breakpoint:** mode=10, `bp_en`=1, `bp_addr`=0x0C; the bench model advances `pc` by 4 per strobe from 0 → strobes at `pc` 0, 4, 8. At the fourth tick, no strobe and `halted_bp`=1. Key → one strobe, `halted_bp`=0, state IDLE, `step_count`=4.
- **Abort:** mode=11, key arriving on the same edge as tick==3 → no strobe, `running`=0, `step_count` unchanged.
- **Reset and wrap:** with `step_count`=0xFFFF, one step → 0x0000. Then `Reset`=0 mid-RUN → after that edge `running`=`cpu_step`=`halted_bp`=0, `step_count`=0, and no strobe occurs afterwards.
